// File: rtl/flashrom_wb_pkg.sv
// Shared types and widths for the flashROM Wishbone controller.
// The controller's state type and the bus/ROM widths used by the top and the fetch engine.
package flashrom_wb_pkg;

    localparam int ROM_AW         = 7;
    localparam int ROM_DW         = 8;
    localparam int WB_DW          = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int MAC_MAX_BYTES  = 6;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_RD,
        ST_ACK,
        ST_ERR
    } state_e;

endpackage : flashrom_wb_pkg

// File: rtl/flashrom_byte_fetch.sv
// Single-byte flashROM read sequencer: holds the ROM address for ROM_LAT
// cycles and flags the last of them, when rom_dout_i is valid.
module flashrom_byte_fetch
    import flashrom_wb_pkg::*;
#(
    parameter int                 ROM_LAT  = 2,
    parameter logic [ROM_AW-1:0]  RST_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ROM_AW-1:0] addr_i,
    input  logic [ROM_DW-1:0] rom_dout_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    output logic              byte_valid_o,
    output logic [ROM_DW-1:0] byte_data_o
);

    localparam logic [1:0] LAST_CNT = 2'(ROM_LAT - 1);

    logic [ROM_AW-1:0] addr_q, addr_d;
    logic [1:0]        cnt_q,  cnt_d;
    logic              active_q, active_d;

    assign rom_addr_o   = addr_q;
    assign byte_valid_o = active_q && (cnt_q == LAST_CNT);
    assign byte_data_o  = rom_dout_i;

    // A start on the capture cycle chains the next byte with no idle gap;
    // without one the engine parks, leaving the ROM address where it was.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start_i) begin
            addr_d   = addr_i;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (byte_valid_o) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (active_q) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Comes out of reset already fetching the first boot byte at RST_ADDR.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q   <= RST_ADDR;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the values from before this edge.
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule : flashrom_byte_fetch

// File: rtl/flashrom_wb_ctrl.sv
// flashROM sequencer shared between the boot-time MAC loader and a
// read-only 32-bit Wishbone classic slave (big-endian word assembly).
module flashrom_wb_ctrl
    import flashrom_wb_pkg::*;
#(
    parameter int                ROM_LAT    = 2,
    parameter logic [ROM_AW-1:0] MAC_OFFSET = 7'h00,
    parameter int                MAC_BYTES  = 6
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [WB_DW-1:0]     wb_dat_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    output logic [WB_DW-1:0]     wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic [ROM_AW-1:0]    rom_addr_o,
    input  logic [ROM_DW-1:0]    rom_dout_i,
    output logic [47:0]          mac_addr_o,
    output logic                 boot_done_o
);

    localparam logic [2:0] MAC_LAST  = 3'(MAC_BYTES - 1);
    localparam logic [1:0] WORD_LAST = 2'(BYTES_PER_WORD - 1);

    state_e state_q, state_d;

    logic [2:0]                                idx_q,  idx_d;
    logic [4:0]                                base_q, base_d;
    logic [BYTES_PER_WORD-1:0][ROM_DW-1:0]     dat_q,  dat_d;
    logic [MAC_MAX_BYTES-1:0][ROM_DW-1:0]      mac_q,  mac_d;
    logic                                      done_q, done_d;

    logic              fetch_start;
    logic [ROM_AW-1:0] fetch_addr;
    logic              byte_valid;
    logic [ROM_DW-1:0] byte_data;

    logic rd_req, wr_req, boot_last, word_last;

    // Write data, byte selects and the address bits outside the ROM window
    // have no function in a read-only word port.
    logic unused_inputs;
    assign unused_inputs = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:7], wb_adr_i[1:0]};

    assign rd_req    = wb_cyc_i && wb_stb_i && !wb_we_i;
    assign wr_req    = wb_cyc_i && wb_stb_i &&  wb_we_i;
    assign boot_last = (idx_q == MAC_LAST);
    assign word_last = (idx_q[1:0] == WORD_LAST);

    flashrom_byte_fetch #(
        .ROM_LAT  (ROM_LAT),
        .RST_ADDR (MAC_OFFSET)
    ) u_fetch (
        .clk_i        (wb_clk_i),
        .rst_n_i      (wb_rst_n_i),
        .start_i      (fetch_start),
        .addr_i       (fetch_addr),
        .rom_dout_i   (rom_dout_i),
        .rom_addr_o   (rom_addr_o),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: if (byte_valid && boot_last) state_d = ST_IDLE;
            ST_IDLE: begin
                if (wr_req)      state_d = ST_ERR;
                else if (rd_req) state_d = ST_RD;
            end
            ST_RD: begin
                if (!wb_cyc_i)                    state_d = ST_IDLE;
                else if (byte_valid && word_last) state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_BOOT;
        endcase
    end

    // Fetch requests: the first byte of a word is launched from IDLE, every
    // following byte is chained on the previous byte's capture cycle.
    always_comb begin
        wb_ack_o    = (state_q == ST_ACK);
        wb_err_o    = (state_q == ST_ERR);
        fetch_start = 1'b0;
        fetch_addr  = rom_addr_o;
        case (state_q)
            ST_BOOT: begin
                if (byte_valid && !boot_last) begin
                    fetch_start = 1'b1;
                    fetch_addr  = MAC_OFFSET + ROM_AW'(idx_q) + 7'd1;
                end
            end
            ST_IDLE: begin
                if (rd_req) begin
                    fetch_start = 1'b1;
                    fetch_addr  = {wb_adr_i[6:2], 2'b00};
                end
            end
            ST_RD: begin
                if (wb_cyc_i && byte_valid && !word_last) begin
                    fetch_start = 1'b1;
                    fetch_addr  = {base_q, idx_q[1:0] + 2'd1};
                end
            end
            default: ;
        endcase
    end

    // Byte placement: MAC byte i lands in the i-th most significant byte,
    // word byte k likewise (big-endian).
    always_comb begin
        idx_d  = idx_q;
        base_d = base_q;
        dat_d  = dat_q;
        mac_d  = mac_q;
        done_d = done_q;
        case (state_q)
            ST_BOOT: begin
                if (byte_valid) begin
                    mac_d[3'(MAC_MAX_BYTES - 1) - idx_q] = byte_data;
                    if (boot_last) begin
                        idx_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (rd_req) begin
                    base_d = wb_adr_i[6:2];
                    idx_d  = '0;
                end
            end
            ST_RD: begin
                if (wb_cyc_i && byte_valid) begin
                    dat_d[WORD_LAST - idx_q[1:0]] = byte_data;
                    idx_d = word_last ? 3'd0 : idx_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            idx_q  <= '0;
            base_q <= '0;
            dat_q  <= '0;
            mac_q  <= '0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            base_q <= base_d;
            dat_q  <= dat_d;
            mac_q  <= mac_d;
            done_q <= done_d;
        end
    end

    assign wb_dat_o    = dat_q;
    assign mac_addr_o  = mac_q;
    assign boot_done_o = done_q;

endmodule : flashrom_wb_ctrl

// File: tb/tb_flashrom_wb_ctrl.sv
// Directed bench for flashrom_wb_ctrl: ROM model with two-cycle read,
// content byte[a] = a + 8'h10.
module tb_flashrom_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat_in = '0;
    logic [3:0]  wb_sel = 4'hF;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [6:0]  rom_addr;
    logic [7:0]  rom_dout;
    logic [47:0] mac_addr;
    logic        boot_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Clocked ROM: data for an address is valid from the second cycle on.
    always @(posedge clk) rom_dout <= 8'(rom_addr) + 8'h10;

    flashrom_wb_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wb_adr_i    (wb_adr),
        .wb_dat_i    (wb_dat_in),
        .wb_sel_i    (wb_sel),
        .wb_we_i     (wb_we),
        .wb_cyc_i    (wb_cyc),
        .wb_stb_i    (wb_stb),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .wb_err_o    (wb_err_o),
        .rom_addr_o  (rom_addr),
        .rom_dout_i  (rom_dout),
        .mac_addr_o  (mac_addr),
        .boot_done_o (boot_done)
    );

    // Issues one request from an IDLE cycle; lat counts edges until the
    // expected acknowledge, other flags the wrong acknowledge, nxt is the
    // expected acknowledge one cycle later.
    task automatic bus_req(input logic [31:0] adr, input logic we, output int lat,
                           output logic [31:0] data, output logic other, output logic nxt);
        @(negedge clk);
        wb_adr = adr; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
        lat = -1; other = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if ((we ? wb_ack_o : wb_err_o) !== 1'b0) other = 1'b1;
            if ((we ? wb_err_o : wb_ack_o) === 1'b1) begin
                lat = i;
                break;
            end
        end
        data = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        nxt = we ? wb_err_o : wb_ack_o;
    endtask

    task automatic wait_boot(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (boot_done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_read(input string name, input logic [31:0] adr, input logic [31:0] exp);
        int lat; logic [31:0] data; logic other, nxt;
        bus_req(adr, 1'b0, lat, data, other, nxt);
        vectors++;
        if (lat !== 9) begin miscompares++; $display("FAIL %s_latency: got %0d expected 9", name, lat); end
        vectors++;
        if (data !== exp) begin miscompares++; $display("FAIL %s_data: got %h expected %h", name, data, exp); end
        vectors++;
        if (other !== 1'b0) begin miscompares++; $display("FAIL %s_err: got %b expected 0", name, other); end
        vectors++;
        if (nxt !== 1'b0) begin miscompares++; $display("FAIL %s_ack_width: ack still %b one cycle later", name, nxt); end
    endtask

    task automatic test_reset();
        int n;
        #12;
        vectors++;
        if ({wb_dat_o, wb_ack_o, wb_err_o, mac_addr, boot_done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: dat=%h ack=%b err=%b mac=%h done=%b expected all 0",
                     wb_dat_o, wb_ack_o, wb_err_o, mac_addr, boot_done);
        end
        vectors++;
        if (rom_addr !== 7'h00) begin miscompares++; $display("FAIL reset_rom_addr: got %h expected 00", rom_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_boot(n);
        vectors++;
        if (n !== 12) begin miscompares++; $display("FAIL boot_cycles: got %0d expected 12", n); end
        vectors++;
        if (mac_addr !== 48'h101112131415) begin
            miscompares++; $display("FAIL boot_mac: got %h expected 101112131415", mac_addr);
        end
    endtask

    task automatic test_read_basic();
        check_read("rd04", 32'h04, 32'h14151617);
    endtask

    task automatic test_read_wrap();
        check_read("rd7c", 32'h7C, 32'h8C8D8E8F);
        check_read("rd80", 32'h80, 32'h10111213);
    endtask

    task automatic test_write();
        int lat; logic [31:0] data; logic other, nxt;
        bus_req(32'h00, 1'b1, lat, data, other, nxt);
        vectors++;
        if (lat !== 1) begin miscompares++; $display("FAIL wr_err_latency: got %0d expected 1", lat); end
        vectors++;
        if (other !== 1'b0) begin miscompares++; $display("FAIL wr_no_ack: got %b expected 0", other); end
        vectors++;
        if (data !== 32'h10111213) begin miscompares++; $display("FAIL wr_dat_hold: got %h expected 10111213", data); end
        vectors++;
        if (nxt !== 1'b0) begin miscompares++; $display("FAIL wr_err_width: err still %b one cycle later", nxt); end
        vectors++;
        if (rom_addr !== 7'h03) begin miscompares++; $display("FAIL wr_rom_addr: got %h expected 03", rom_addr); end
    endtask

    task automatic test_abort();
        logic acked = 1'b0;
        @(negedge clk);
        wb_adr = 32'h10; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        repeat (3) @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) acked = 1'b1;
        end
        vectors++;
        if (acked !== 1'b0) begin miscompares++; $display("FAIL abort_no_ack: got ack/err %b expected 0", acked); end
        check_read("rd20_after_abort", 32'h20, 32'h30313233);
    endtask

    task automatic test_boot_hold();
        int lat = -1; int done_at = -1; logic early = 1'b0; logic [31:0] data;
        @(negedge clk);
        rst_n = 1'b0;
        wb_adr = 32'h08; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (boot_done === 1'b1 && done_at < 0) done_at = i;
            if (boot_done !== 1'b1 && (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0)) early = 1'b1;
            if (wb_ack_o === 1'b1) begin
                lat = i;
                break;
            end
        end
        data = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        vectors++;
        if (early !== 1'b0) begin miscompares++; $display("FAIL hold_early_ack: got %b expected 0", early); end
        vectors++;
        if (done_at !== 12) begin miscompares++; $display("FAIL hold_boot_cycles: got %0d expected 12", done_at); end
        vectors++;
        if (lat !== 21) begin miscompares++; $display("FAIL hold_ack_cycle: got %0d expected 21", lat); end
        vectors++;
        if (data !== 32'h18191A1B) begin miscompares++; $display("FAIL hold_data: got %h expected 18191a1b", data); end
        @(negedge clk);
        vectors++;
        if (wb_ack_o !== 1'b0) begin miscompares++; $display("FAIL hold_ack_width: got %b expected 0", wb_ack_o); end
    endtask

    task automatic test_reset_mid_read();
        int n;
        @(negedge clk);
        wb_adr = 32'h0C; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({wb_dat_o, wb_ack_o, wb_err_o, mac_addr, boot_done} !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs: dat=%h ack=%b err=%b mac=%h done=%b expected all 0",
                     wb_dat_o, wb_ack_o, wb_err_o, mac_addr, boot_done);
        end
        vectors++;
        if (rom_addr !== 7'h00) begin miscompares++; $display("FAIL midrst_rom_addr: got %h expected 00", rom_addr); end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_boot(n);
        vectors++;
        if (n !== 12) begin miscompares++; $display("FAIL midrst_boot_cycles: got %0d expected 12", n); end
        vectors++;
        if (mac_addr !== 48'h101112131415) begin
            miscompares++; $display("FAIL midrst_mac: got %h expected 101112131415", mac_addr);
        end
        check_read("rd0c_after_reset", 32'h0C, 32'h1C1D1E1F);
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_read_wrap();
        test_write();
        test_abort();
        test_boot_hold();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_flashrom_wb_ctrl
